// File: rtl/mux_pkg.sv
// Shared constants and the select-width helper for the registered N-to-1 mux.
package mux_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ERR_CNT_W   = 8;
  localparam int unsigned ERR_CNT_MAX = (32'd1 << ERR_CNT_W) - 32'd1;

  // Smallest r with 2**r >= n; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/muxn_reg_if.sv
// Bundle of the mux data/handshake/error signals with producer/consumer views.
interface muxn_reg_if
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned N     = 3,
  parameter int unsigned SEL_W = clog2(N)
);

  logic [N*WIDTH-1:0]   in_data;
  logic [SEL_W-1:0]     sel;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 sel_err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 err_clr;

  modport master (
    output in_data, sel, in_valid, out_ready, err_clr,
    input  in_ready, out_data, out_valid, sel_err, err_cnt
  );

  modport slave (
    input  in_data, sel, in_valid, out_ready, err_clr,
    output in_ready, out_data, out_valid, sel_err, err_cnt
  );

endinterface

// File: rtl/mux_n_comb.sv
// Pure combinational N-to-1 word select; flags whether sel names a real input.
module mux_n_comb #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 3,
  parameter int unsigned SEL_W = 2
) (
  input  logic [N*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [WIDTH-1:0]   data_c_o,
  output logic               legal_c_o
);

  // Out-of-range selects yield zero so nothing downstream ever sees X.
  always_comb begin
    data_c_o  = '0;
    legal_c_o = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (32'(sel_i) == k) begin
        data_c_o  = data_i[k*WIDTH +: WIDTH];
        legal_c_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/muxn_reg.sv
// Registered N-to-1 mux with valid/ready handshake and sticky out-of-range
// select error reporting (flag plus saturating counter).
module muxn_reg
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned N     = 3,
  parameter int unsigned SEL_W = clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sel_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);

  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 sel_err_q, sel_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0]     sel_data_c;
  logic                 sel_legal_c;
  logic                 accept_c;
  logic                 legal_acc_c;
  logic                 illegal_acc_c;

  mux_n_comb #(
    .WIDTH (WIDTH),
    .N     (N),
    .SEL_W (SEL_W)
  ) u_mux (
    .data_i    (in_data),
    .sel_i     (sel),
    .data_c_o  (sel_data_c),
    .legal_c_o (sel_legal_c)
  );

  assign in_ready      = !out_valid_q || out_ready;
  assign accept_c      = in_valid && in_ready;
  assign legal_acc_c   = accept_c && sel_legal_c;
  assign illegal_acc_c = accept_c && !sel_legal_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Output slot: drain on consume, refill on legal accept (refill wins).
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (legal_acc_c) begin
      out_data_d  = sel_data_c;
      out_valid_d = 1'b1;
    end
  end

  // An illegal accept in the same cycle as a clear counts from zero.
  always_comb begin
    sel_err_d = sel_err_q;
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      sel_err_d = 1'b0;
      err_cnt_d = '0;
    end
    if (illegal_acc_c) begin
      sel_err_d = 1'b1;
      if (err_clr)                                     err_cnt_d = ERR_CNT_W'(1);
      else if (err_cnt_q != ERR_CNT_W'(ERR_CNT_MAX))   err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_muxn_reg.sv
// Bench for muxn_reg: directed scenarios plus random traffic on a 32b/3-input
// instance (a) and an 8b/5-input instance (b), checked against a cycle model.
module tb_muxn_reg;

  logic clk;
  logic reset_n;

  muxn_reg_if #(.WIDTH(32), .N(3), .SEL_W(2)) ia ();
  muxn_reg_if #(.WIDTH(8),  .N(5), .SEL_W(3)) ib ();

  muxn_reg #(.WIDTH(32), .N(3), .SEL_W(2)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .in_data(ia.in_data), .sel(ia.sel), .in_valid(ia.in_valid), .in_ready(ia.in_ready),
    .out_data(ia.out_data), .out_valid(ia.out_valid), .out_ready(ia.out_ready),
    .sel_err(ia.sel_err), .err_cnt(ia.err_cnt), .err_clr(ia.err_clr)
  );

  muxn_reg #(.WIDTH(8), .N(5), .SEL_W(3)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .in_data(ib.in_data), .sel(ib.sel), .in_valid(ib.in_valid), .in_ready(ib.in_ready),
    .out_data(ib.out_data), .out_valid(ib.out_valid), .out_ready(ib.out_ready),
    .sel_err(ib.sel_err), .err_cnt(ib.err_cnt), .err_clr(ib.err_clr)
  );

  // Stimulus variables, index 0 = instance a, 1 = instance b
  logic [31:0] wa [3];
  logic [7:0]  wb [5];
  logic [3:0]  sel_v [2];
  logic        iv [2];
  logic        ordy [2];
  logic        eclr [2];

  // Reference model state
  logic [31:0] m_data [2];
  logic        m_valid [2];
  logic        m_err [2];
  int          m_cnt [2];

  int checks = 0;
  int errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    for (int k = 0; k < 3; k++) ia.in_data[k*32 +: 32] = wa[k];
    ia.sel       = sel_v[0][1:0];
    ia.in_valid  = iv[0];
    ia.out_ready = ordy[0];
    ia.err_clr   = eclr[0];
  end

  always_comb begin
    for (int k = 0; k < 5; k++) ib.in_data[k*8 +: 8] = wb[k];
    ib.sel       = sel_v[1][2:0];
    ib.in_valid  = iv[1];
    ib.out_ready = ordy[1];
    ib.err_clr   = eclr[1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_data[d] = '0; m_valid[d] = 1'b0; m_err[d] = 1'b0; m_cnt[d] = 0;
    end
  endtask

  // Next-cycle expectations from the handshake rules, given current inputs.
  task automatic model_step(input int d);
    logic        acc, legal;
    logic [31:0] word;
    int          lim;
    lim   = (d == 0) ? 3 : 5;
    acc   = iv[d] && (!m_valid[d] || ordy[d]);
    legal = acc && (int'(sel_v[d]) < lim);
    word  = '0;
    if (d == 0) begin
      for (int k = 0; k < 3; k++) if (int'(sel_v[d]) == k) word = wa[k];
    end else begin
      for (int k = 0; k < 5; k++) if (int'(sel_v[d]) == k) word = 32'(wb[k]);
    end
    if (m_valid[d] && ordy[d]) m_valid[d] = 1'b0;
    if (legal) begin
      m_valid[d] = 1'b1;
      m_data[d]  = word;
    end
    if (eclr[d]) begin
      m_err[d] = 1'b0;
      m_cnt[d] = 0;
    end
    if (acc && !legal) begin
      m_err[d] = 1'b1;
      m_cnt[d] = (m_cnt[d] + 1 > 255) ? 255 : m_cnt[d] + 1;
    end
  endtask

  task automatic check_ready(input int d);
    logic exp_rdy;
    exp_rdy = !m_valid[d] || ordy[d];
    if (d == 0) check("a.in_ready", 32'(ia.in_ready), 32'(exp_rdy));
    else        check("b.in_ready", 32'(ib.in_ready), 32'(exp_rdy));
  endtask

  task automatic check_outs(input int d);
    if (d == 0) begin
      check("a.out_data",  ia.out_data,       m_data[0]);
      check("a.out_valid", 32'(ia.out_valid), 32'(m_valid[0]));
      check("a.sel_err",   32'(ia.sel_err),   32'(m_err[0]));
      check("a.err_cnt",   32'(ia.err_cnt),   32'(m_cnt[0]));
    end else begin
      check("b.out_data",  32'(ib.out_data),  m_data[1]);
      check("b.out_valid", 32'(ib.out_valid), 32'(m_valid[1]));
      check("b.sel_err",   32'(ib.sel_err),   32'(m_err[1]));
      check("b.err_cnt",   32'(ib.err_cnt),   32'(m_cnt[1]));
    end
  endtask

  // Inputs must be set before calling; samples away from the rising edge.
  task automatic cycle();
    #1;
    for (int d = 0; d < 2; d++) begin
      check_ready(d);
      model_step(d);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check_outs(d);
  endtask

  task automatic drive(input int d, input int s, input logic v, input logic r, input logic c);
    sel_v[d] = 4'(s);
    iv[d]    = v;
    ordy[d]  = r;
    eclr[d]  = c;
  endtask

  initial begin
    reset_n = 1'b0;
    wa[0] = 32'h11111111; wa[1] = 32'h22222222; wa[2] = 32'h33333333;
    for (int k = 0; k < 5; k++) wb[k] = 8'(8'hA0 + k);
    for (int d = 0; d < 2; d++) drive(d, 0, 1'b0, 1'b0, 1'b0);
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check_outs(d);
    reset_n = 1'b1;

    // Single legal transfer right after reset
    drive(0, 1, 1'b1, 1'b1, 1'b0);
    cycle();
    check("a.first_b", ia.out_data, 32'h22222222);

    // Back-to-back stream
    for (int i = 0; i < 4; i++) begin
      drive(0, (i == 3) ? 0 : i, 1'b1, 1'b1, 1'b0);
      cycle();
    end
    check("a.stream_end", ia.out_data, 32'h11111111);

    // Backpressure: load C, stall three cycles with A offered, then release
    drive(0, 2, 1'b1, 1'b1, 1'b0);
    cycle();
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle();
    check("a.stall_hold", ia.out_data, 32'h33333333);
    drive(0, 0, 1'b1, 1'b1, 1'b0);
    cycle();
    check("a.stall_release", ia.out_data, 32'h11111111);
    drive(0, 0, 1'b0, 1'b1, 1'b0);
    cycle();

    // Illegal select, saturation, and clear coinciding with an illegal accept
    drive(0, 3, 1'b1, 1'b1, 1'b0);
    cycle();
    check("a.illegal_cnt1", 32'(ia.err_cnt), 32'd1);
    check("a.illegal_hold", ia.out_data, 32'h11111111);
    repeat (299) cycle();
    check("a.sat_cnt", 32'(ia.err_cnt), 32'd255);
    drive(0, 3, 1'b1, 1'b1, 1'b1);
    cycle();
    check("a.clr_illegal_cnt", 32'(ia.err_cnt), 32'd1);
    check("a.clr_illegal_err", 32'(ia.sel_err), 32'd1);
    drive(0, 0, 1'b0, 1'b1, 1'b1);
    cycle();
    drive(0, 0, 1'b0, 1'b1, 1'b0);

    // Narrow instance: stream all inputs, then every illegal select
    for (int i = 0; i < 6; i++) begin
      drive(1, i % 5, 1'b1, 1'b1, 1'b0);
      cycle();
    end
    for (int s = 5; s < 8; s++) begin
      drive(1, s, 1'b1, 1'b1, 1'b0);
      cycle();
    end
    check("b.illegal_cnt3", 32'(ib.err_cnt), 32'd3);
    check("b.illegal_hold", 32'(ib.out_data), 32'h000000A0);
    drive(1, 0, 1'b0, 1'b1, 1'b0);

    // Random traffic on both instances, data changing every cycle
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 3; k++) wa[k] = $urandom;
      for (int k = 0; k < 5; k++) wb[k] = 8'($urandom);
      drive(0, int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
      drive(1, int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
      cycle();
    end

    // Asynchronous reset while a result is pending and the error flag is set
    for (int d = 0; d < 2; d++) drive(d, 0, 1'b0, 1'b1, 1'b0);
    cycle();
    drive(0, 3, 1'b1, 1'b1, 1'b0);
    cycle();
    drive(0, 1, 1'b1, 1'b0, 1'b0);
    cycle();
    check("a.pre_rst_valid", 32'(ia.out_valid), 32'd1);
    check("a.pre_rst_err",   32'(ia.sel_err),   32'd1);
    reset_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) check_outs(d);
    #2;
    reset_n = 1'b1;

    // First edge after release accepts
    drive(0, 2, 1'b1, 1'b1, 1'b0);
    cycle();
    check("a.post_rst_accept", ia.out_data, wa[2]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
